// File: rtl/udma_adc_ts_pkg.sv
// Shared types for the uDMA ADC timestamp capture block.
// The ts_evt_t fields are sized to the widest supported channel-id and timestamp widths.
package udma_adc_ts_pkg;

  localparam int DROP_CNT_WIDTH = 16;
  localparam int TS_DATA_MAX_W  = 28;
  localparam int TS_CHID_MAX_W  = 4;

  typedef struct packed {
    logic [TS_CHID_MAX_W-1:0] chid;
    logic [TS_DATA_MAX_W-1:0] data;
  } ts_evt_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } out_state_e;

endpackage

// File: rtl/adc_ts_evt_fifo.sv
// Synchronous FIFO of stamped events; the read data is valid only while not empty.
// A push is refused whenever the FIFO is full, even if a pop happens in the same cycle.
module adc_ts_evt_fifo
  import udma_adc_ts_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  ts_evt_t wr_data,
  input  logic    pop,
  output ts_evt_t rd_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  ts_evt_t      mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/udma_adc_ts_capture.sv
// Stamps rising edges on NB_CH event lines and hands them out as a toggle-valid bundle.
// Optional dropped-event counter: define ADC_TS_DROP_CNT_EN.
module udma_adc_ts_capture
  import udma_adc_ts_pkg::*;
#(
  parameter int NB_CH         = 8,
  parameter int TS_DATA_WIDTH = 28,
  parameter int TS_CHID_WIDTH = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int MIN_HOLD_CYC  = 8,
  parameter int PRESC_WIDTH   = 8
) (
  input  logic                      ts_clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [NB_CH-1:0]          ch_mask_i,
  input  logic [PRESC_WIDTH-1:0]    presc_i,
  input  logic                      ts_clr_i,
  input  logic [NB_CH-1:0]          ch_evt_i,
  output logic                      ts_valid_o,
  output logic [TS_CHID_WIDTH-1:0]  ts_chid_o,
  output logic [TS_DATA_WIDTH-1:0]  ts_data_o,
  output logic                      fifo_full_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int HOLD_W = $clog2(MIN_HOLD_CYC);

  logic [PRESC_WIDTH-1:0]   presc_cnt;
  logic [TS_DATA_WIDTH-1:0] ts_cnt;
  logic [NB_CH-1:0]         evt_q;
  logic [NB_CH-1:0]         rise;
  logic [NB_CH-1:0]         pend;
  logic [NB_CH-1:0]         grant;
  logic [NB_CH-1:0]         sel;
  logic [TS_DATA_WIDTH-1:0] stamp [NB_CH];
  logic                     found;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  ts_evt_t                  wr_evt;
  ts_evt_t                  rd_evt;
  out_state_e               state;
  logic [HOLD_W-1:0]        hold_cnt;
  logic                     unused_rd_bits;

  // Counter stage: presc_cnt >= presc_i also recovers if presc_i is lowered mid-count.
  always_ff @(posedge ts_clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt <= '0;
      ts_cnt    <= '0;
    end else if (ts_clr_i) begin
      presc_cnt <= '0;
      ts_cnt    <= '0;
    end else if (en_i) begin
      if (presc_cnt >= presc_i) begin
        presc_cnt <= '0;
        ts_cnt    <= ts_cnt + TS_DATA_WIDTH'(1);
      end else begin
        presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
      end
    end
  end

  assign rise = ch_evt_i & ~evt_q & ch_mask_i & {NB_CH{en_i}};

  // Grant stage: lowest-index pending channel wins.
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    wr_evt = '0;
    for (int i = 0; i < NB_CH; i++) begin
      if (pend[i] && !found) begin
        found       = 1'b1;
        sel[i]      = 1'b1;
        wr_evt.chid = TS_CHID_MAX_W'(i);
        wr_evt.data = TS_DATA_MAX_W'(stamp[i]);
      end
    end
  end

  assign push  = found && !full;
  assign grant = push ? sel : '0;

  // Pending stage: a rise on a granted channel re-arms it with a fresh stamp.
  always_ff @(posedge ts_clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q <= '0;
      pend  <= '0;
      for (int i = 0; i < NB_CH; i++) stamp[i] <= '0;
    end else begin
      evt_q <= ch_evt_i;
      pend  <= (pend & ~grant) | rise;
      for (int i = 0; i < NB_CH; i++) begin
        if (rise[i] && !(pend[i] && !grant[i])) stamp[i] <= ts_cnt;
      end
    end
  end

  adc_ts_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (ts_clk_i),
    .rst    (rst_i),
    .push   (push),
    .wr_data(wr_evt),
    .pop    (pop),
    .rd_data(rd_evt),
    .full   (full),
    .empty  (empty)
  );

  assign fifo_full_o    = full;
  assign pop            = (state == IDLE) && !empty;
  assign unused_rd_bits = ^rd_evt;

  // Output stage: the bundle only moves on a toggle and then holds for MIN_HOLD_CYC cycles.
  always_ff @(posedge ts_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      ts_valid_o <= 1'b0;
      ts_chid_o  <= '0;
      ts_data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            ts_valid_o <= ~ts_valid_o;
            ts_chid_o  <= rd_evt.chid[TS_CHID_WIDTH-1:0];
            ts_data_o  <= rd_evt.data[TS_DATA_WIDTH-1:0];
            hold_cnt   <= HOLD_W'(MIN_HOLD_CYC-1);
            state      <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
          if (hold_cnt == HOLD_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_TS_DROP_CNT_EN
  logic [NB_CH-1:0]          drop;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  function automatic logic [DROP_CNT_WIDTH-1:0] popcount(input logic [NB_CH-1:0] v);
    logic [DROP_CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < NB_CH; i++) if (v[i]) c = c + DROP_CNT_WIDTH'(1);
    return c;
  endfunction

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_add(input logic [DROP_CNT_WIDTH-1:0] a,
                                                        input logic [DROP_CNT_WIDTH-1:0] b);
    logic [DROP_CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DROP_CNT_WIDTH] ? '1 : sum[DROP_CNT_WIDTH-1:0];
  endfunction

  assign drop = rise & pend & ~grant;

  always_ff @(posedge ts_clk_i or posedge rst_i) begin
    if (rst_i)         drop_cnt <= '0;
    else if (ts_clr_i) drop_cnt <= '0;
    else               drop_cnt <= sat_add(drop_cnt, popcount(drop));
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_udma_adc_ts_capture.sv
// Directed bench for udma_adc_ts_capture with a narrowed timestamp so wrap-around is reachable.
module tb_udma_adc_ts_capture;

  localparam int TSW = 10;

  logic           clk;
  logic           rst;
  logic           en;
  logic [7:0]     mask;
  logic [7:0]     presc;
  logic           ts_clr;
  logic [7:0]     evt;
  logic           ts_valid;
  logic [3:0]     ts_chid;
  logic [TSW-1:0] ts_data;
  logic           fifo_full;
  logic [15:0]    drop_cnt;

  typedef struct {
    int chid;
    int data;
    int cyc;
  } tog_t;

  tog_t tq[$];
  int   cyc;
  int   checks;
  int   errors;
  int   clr_cyc;
  int   rc;
  int   d;
  int   drop_exp;
  logic prev_valid;
  logic full_seen;

  udma_adc_ts_capture #(
    .TS_DATA_WIDTH(TSW)
  ) dut (
    .ts_clk_i   (clk),
    .rst_i      (rst),
    .en_i       (en),
    .ch_mask_i  (mask),
    .presc_i    (presc),
    .ts_clr_i   (ts_clr),
    .ch_evt_i   (evt),
    .ts_valid_o (ts_valid),
    .ts_chid_o  (ts_chid),
    .ts_data_o  (ts_data),
    .fifo_full_o(fifo_full),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every output toggle with the cycle it became visible.
  initial begin
    cyc        = 0;
    prev_valid = 1'b0;
    full_seen  = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        prev_valid = ts_valid;
      end else if (ts_valid != prev_valid) begin
        prev_valid = ts_valid;
        tq.push_back('{chid: int'(ts_chid), data: int'(ts_data), cyc: cyc});
      end
      if (fifo_full) full_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clr_ts();
    ts_clr = 1'b1;
    tick();
    ts_clr  = 1'b0;
    clr_cyc = cyc;
  endtask

  task automatic expect_tog(input int idx, input int chid, input int data, input int c);
    if (idx >= tq.size()) begin
      check($sformatf("tog%0d_present", idx), tq.size(), idx + 1);
    end else begin
      check($sformatf("tog%0d_chid", idx), tq[idx].chid, chid);
      check($sformatf("tog%0d_data", idx), tq[idx].data, data);
      check($sformatf("tog%0d_cyc", idx), tq[idx].cyc, c);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef ADC_TS_DROP_CNT_EN
    drop_exp = 1;
`else
    drop_exp = 0;
`endif
    rst    = 1'b1;
    en     = 1'b0;
    mask   = 8'h00;
    presc  = 8'd0;
    ts_clr = 1'b0;
    evt    = 8'h00;
    tick(3);
    check("rst_valid", ts_valid, 0);
    check("rst_chid", ts_chid, 0);
    check("rst_data", ts_data, 0);
    check("rst_full", fifo_full, 0);
    check("rst_drop", drop_cnt, 0);
    rst  = 1'b0;
    en   = 1'b1;
    mask = 8'hFF;
    tick(2);

    // Prescaled stamp: 20 cycles at presc 3 after clear gives 5.
    presc = 8'd3;
    clr_ts();
    wait_until(clr_cyc + 20);
    evt = 8'h01;
    rc  = cyc;
    tick();
    evt = 8'h00;
    tick(15);
    check("t1_count", tq.size(), 1);
    expect_tog(0, 0, 5, rc + 3);

    // Simultaneous rises: lower channel first, same stamp, MIN_HOLD_CYC apart.
    tq.delete();
    presc = 8'd0;
    clr_ts();
    wait_until(clr_cyc + 10);
    evt = 8'h22;
    rc  = cyc;
    tick();
    evt = 8'h00;
    tick(20);
    check("t2_count", tq.size(), 2);
    expect_tog(0, 1, 10, rc + 3);
    expect_tog(1, 5, 10, rc + 11);

    // Burst on all channels: FIFO fills, pend absorbs the rest, no drops.
    tq.delete();
    full_seen = 1'b0;
    clr_ts();
    wait_until(clr_cyc + 2);
    rc = cyc;
    for (int i = 0; i < 8; i++) begin
      evt[i] = 1'b1;
      tick();
    end
    evt = 8'h00;
    tick(70);
    check("t3_count", tq.size(), 8);
    for (int i = 0; i < 8; i++) expect_tog(i, i, 2 + i, rc + 3 + 8 * i);
    check("t3_full_seen", full_seen, 1);
    check("t3_drop", drop_cnt, 0);

    // Re-rise on a pending channel while the FIFO is full is dropped.
    tq.delete();
    clr_ts();
    wait_until(clr_cyc + 4);
    evt = 8'h7B;
    d   = cyc;
    tick(6);
    evt[2] = 1'b1;
    tick();
    evt[2] = 1'b0;
    tick();
    check("t4_full", fifo_full, 1);
    evt[2] = 1'b1;
    tick(2);
    check("t4_drop", drop_cnt, drop_exp);
    evt = 8'h00;
    tick(50);
    check("t4_count", tq.size(), 7);
    expect_tog(0, 0, 4, d + 3);
    expect_tog(1, 1, 4, d + 11);
    expect_tog(2, 3, 4, d + 19);
    expect_tog(3, 4, 4, d + 27);
    expect_tog(4, 5, 4, d + 35);
    expect_tog(5, 2, 10, d + 43);
    expect_tog(6, 6, 4, d + 51);

    // Wrap-around: the stamp after all-ones is 0.
    tq.delete();
    clr_ts();
    check("t5_drop_clr", drop_cnt, 0);
    wait_until(clr_cyc + 1023);
    evt = 8'h10;
    rc  = cyc;
    tick();
    evt = 8'h18;
    tick();
    evt = 8'h00;
    tick(20);
    check("t5_count", tq.size(), 2);
    expect_tog(0, 4, 1023, rc + 3);
    expect_tog(1, 3, 0, rc + 11);

    // Reset with three events queued discards them.
    tq.delete();
    clr_ts();
    wait_until(clr_cyc + 2);
    evt = 8'h0F;
    d   = cyc;
    tick(5);
    rst = 1'b1;
    #1;
    check("t6_valid", ts_valid, 0);
    check("t6_full", fifo_full, 0);
    check("t6_chid", ts_chid, 0);
    check("t6_data", ts_data, 0);
    check("t6_drop", drop_cnt, 0);
    evt = 8'h00;
    tick(2);
    rst = 1'b0;
    check("t6_pre_count", tq.size(), 1);
    tick(30);
    check("t6_post_count", tq.size(), 1);

    // Masked channel and disabled capture produce nothing.
    mask = 8'h7F;
    evt  = 8'h80;
    tick();
    en  = 1'b0;
    evt = 8'hC0;
    tick();
    evt = 8'h00;
    en  = 1'b1;
    tick(15);
    check("t7_count", tq.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
